// File: rtl/display_mux.sv
// Two-digit multiplexed common-anode 7-segment driver for the oven timer count.
// Frame-coherent BCD snapshot, leading-zero blanking, dead time between slots, timeout blink.
module display_mux #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int BLINK_HZ   = 2,
    parameter int GUARD      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] digit_time,
    input  logic       timeout,
    input  logic       blank_lead,
    output logic [6:0] seg,
    output logic [1:0] dig_en,
    output logic       dp
);
    localparam int DIV = CLK_HZ / REFRESH_HZ;
    localparam int HB  = CLK_HZ / (2 * BLINK_HZ);
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = (HB > 1) ? $clog2(HB) : 1;
    localparam int GW  = $clog2(GUARD + 1);

    localparam logic [PW-1:0] DIV_LAST  = PW'(DIV - 1);
    localparam logic [BW-1:0] HB_LAST   = BW'(HB - 1);
    localparam logic [GW-1:0] GUARD_VAL = GW'(GUARD);

    logic [PW-1:0] pre_reg,   pre_next;
    logic          sel_reg,   sel_next;
    logic [GW-1:0] guard_reg, guard_next;
    logic          run_reg,   run_next;
    logic [7:0]    snap_reg,  snap_next;
    logic          phase_reg, phase_next;
    logic [BW-1:0] blink_reg, blink_next;
    logic [6:0]    seg_reg,   seg_next;
    logic [1:0]    dig_en_reg, dig_en_next;

    logic       tick;
    logic       blanked;
    logic       slot_on;
    logic [6:0] digit_seg [2];

    assign tick = (pre_reg == DIV_LAST);

    // One decoder per snapshot nibble: [0] ones, [1] tens.
    for (genvar gi = 0; gi < 2; gi++) begin : g_decode
        always_comb begin
            digit_seg[gi] = 7'b0111111;
            case (snap_reg[gi*4 +: 4])
                4'd0: digit_seg[gi] = 7'b1000000;
                4'd1: digit_seg[gi] = 7'b1111001;
                4'd2: digit_seg[gi] = 7'b0100100;
                4'd3: digit_seg[gi] = 7'b0110000;
                4'd4: digit_seg[gi] = 7'b0011001;
                4'd5: digit_seg[gi] = 7'b0010010;
                4'd6: digit_seg[gi] = 7'b0000010;
                4'd7: digit_seg[gi] = 7'b1111000;
                4'd8: digit_seg[gi] = 7'b0000000;
                4'd9: digit_seg[gi] = 7'b0010000;
                default: digit_seg[gi] = 7'b0111111;
            endcase
        end
    end

    always_comb begin
        pre_next   = tick ? '0 : pre_reg + PW'(1);
        sel_next   = tick ? ~sel_reg : sel_reg;
        run_next   = run_reg | tick;
        // Leaving the tens slot is the frame boundary: resample the count.
        snap_next  = (tick && sel_reg) ? digit_time : snap_reg;

        // The dead time holds until the first tick so that the very first
        // enable after reset arrives one full slot plus the guard later.
        guard_next = guard_reg;
        if (tick) begin
            guard_next = GUARD_VAL;
        end else if (run_reg && (guard_reg != '0)) begin
            guard_next = guard_reg - GW'(1);
        end

        blink_next = '0;
        phase_next = 1'b1;
        if (timeout) begin
            if (blink_reg == HB_LAST) begin
                blink_next = '0;
                phase_next = ~phase_reg;
            end else begin
                blink_next = blink_reg + BW'(1);
                phase_next = phase_reg;
            end
        end
    end

    always_comb begin
        blanked     = sel_reg && blank_lead && (snap_reg[7:4] == 4'd0);
        slot_on     = (guard_reg == '0) && phase_reg && !blanked;
        seg_next    = blanked ? 7'b1111111 : digit_seg[sel_reg];
        dig_en_next = 2'b11;
        if (slot_on) begin
            dig_en_next = sel_reg ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_reg    <= '0;
            sel_reg    <= 1'b0;
            guard_reg  <= GUARD_VAL;
            run_reg    <= 1'b0;
            snap_reg   <= 8'h00;
            phase_reg  <= 1'b1;
            blink_reg  <= '0;
            seg_reg    <= 7'b1111111;
            dig_en_reg <= 2'b11;
        end else begin
            pre_reg    <= pre_next;
            sel_reg    <= sel_next;
            guard_reg  <= guard_next;
            run_reg    <= run_next;
            snap_reg   <= snap_next;
            phase_reg  <= phase_next;
            blink_reg  <= blink_next;
            seg_reg    <= seg_next;
            dig_en_reg <= dig_en_next;
        end
    end

    assign seg    = seg_reg;
    assign dig_en = dig_en_reg;
    assign dp     = 1'b1;
endmodule
